sobel_frame_ctrl: RTL
=====================

Name: sobel_frame_ctrl

Overview:
Frame sequencer for the grayscale/Sobel pipeline. It sits between the SPI pixel interface and top_gray_sobel. It arms the pipeline with a one-cycle start pulse and latches the filter select for the whole frame. It gates and counts incoming pixels, counts pixels the pipeline emits, and signals frame completion, with a drain watchdog for lost outputs.

Parameters:
IMG_WIDTH, 24, pixels per row
IMG_HEIGHT, 24, rows per frame
TIMEOUT_CYCLES, 1024, max idle cycles in DRAIN between pipeline outputs before giving up
CNT_W, $clog2(IMG_WIDTH*IMG_HEIGHT+1), width of pixel counters (derived)

Ports:
clk_i  input  1  system clock
nreset_i  input  1  asynchronous active-low reset
frame_start_i  input  1  request to begin a frame (level sampled each cycle)
select_i  input  2  filter mode requested for the next frame
in_valid_i  input  1  SPI side has a new input pixel this cycle
in_ready_o  output  1  controller accepts input pixels
px_ready_sobel_i  input  1  pipeline produced an output pixel this cycle
start_o  output  1  start pulse to pipeline start_i
select_o  output  2  frame-stable select to pipeline select_i
out_valid_o  output  1  registered copy of px_ready_sobel_i, counted pixels only
busy_o  output  1  high in any state except IDLE
frame_done_o  output  1  one-cycle pulse at end of frame
error_o  output  1  sticky frame error flag
in_count_o  output  CNT_W  input pixels accepted this frame
out_count_o  output  CNT_W  output pixels counted this frame

Behaviour:
- Clock is clk_i. Reset is nreset_i, asynchronous active-low; fixed.
- Reset values: all outputs 0; select_o = 2'b00; FSM in IDLE.
- N = IMG_WIDTH*IMG_HEIGHT. An input is accepted when in_valid_i & in_ready_o.
- IDLE: in_ready_o = 0.
  - frame_start_i = 1: latch select_i into select_o; clear in/out counters, watchdog and error_o; go to ARM.
- ARM: exactly one cycle with start_o = 1, then go to RUN. start_o is low in all other states.
- RUN: in_ready_o = 1.
  - Each accepted input increments in_count_o.
  - When the accept that makes in_count_o = N occurs, go to DRAIN next cycle. in_ready_o is 0 from that cycle on, so no input beyond N is ever accepted.
- Output counting (ARM, RUN, DRAIN): each px_ready_sobel_i increments out_count_o and sets out_valid_o one cycle later.
  - Once out_count_o = N, further px_ready_sobel_i is not counted, out_valid_o stays 0, and error_o is set.
- DRAIN:
  - Watchdog increments each cycle without px_ready_sobel_i and clears on px_ready_sobel_i.
  - out_count_o = N: go to DONE.
  - Watchdog reaches TIMEOUT_CYCLES: set error_o and go to DONE.
- DONE: frame_done_o = 1 for one cycle, then go to IDLE. Counters and error_o hold until the next frame start.
- frame_start_i outside IDLE is ignored; no queuing.
- px_ready_sobel_i in IDLE or DONE is ignored: no count, no out_valid_o.
- If out_count_o reaches N while still in RUN, do not exit. Further outputs follow the over-count rule.
- select_o changes only on the IDLE-to-ARM transition.
- Reset asserted mid-frame returns everything to reset values immediately, with no frame_done_o pulse.
- Latency:
  - frame_start_i to start_o: 1 cycle.
  - px_ready_sobel_i to out_valid_o: 1 cycle.
  - Last out_count_o increment to frame_done_o: 2 cycles (DRAIN detect, then DONE).

Optional Feature:
SOBEL_FRAME_ABORT_EN
- Defined: adds input abort_i (1 bit).
  - abort_i = 1 in ARM, RUN or DRAIN forces the next state to DONE, sets error_o, and drops in_ready_o the following cycle.
  - abort_i in IDLE or DONE is ignored.
- Not defined: no abort_i port; frames end only by completion or watchdog.

Test Plan:
- Reset, frame_start_i = 1 with select_i = 2'b10 for 1 cycle -> start_o high exactly 1 cycle 1 cycle later; select_o = 2'b10; busy_o = 1.
- Feed 576 in_valid_i pulses with px_ready_sobel_i echoed 4 cycles after each -> in_count_o = out_count_o = 576; in_ready_o low after the 576th accept; one frame_done_o pulse; error_o = 0.
- Hold in_valid_i high for 600 cycles in RUN -> exactly 576 accepted; in_count_o = 576.
- Frame where the pipeline emits only 570 outputs -> DONE after 1024 idle cycles in DRAIN; error_o = 1; out_count_o = 570.
- Extra px_ready_sobel_i after out_count_o = 576 -> not counted; no out_valid_o; error_o = 1. Also px_ready_sobel_i in IDLE -> no count change.
- Assert nreset_i low mid-RUN (in_count_o = 100) -> all outputs 0 immediately; no frame_done_o. With SOBEL_FRAME_ABORT_EN, abort_i in RUN -> frame_done_o next cycle and error_o = 1.

Source files
------------

// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
//
// Frame sequencer between the SPI pixel interface and top_gray_sobel.
// Arms the pipeline with a one-cycle start pulse, holds the filter select
// stable for the whole frame, gates and counts incoming pixels, counts the
// pixels the pipeline emits, and reports frame completion. A drain watchdog
// ends the frame with an error if the pipeline goes quiet before all
// N = IMG_WIDTH*IMG_HEIGHT output pixels have been seen.
//
// Optional build macro:
//   SOBEL_FRAME_ABORT_EN  adds input abort_i; an abort in ARM/RUN/DRAIN ends
//                         the frame through DONE with error_o set.
//
// Ports:
//   clk_i             system clock
//   nreset_i          asynchronous active-low reset
//   frame_start_i     frame request, sampled in IDLE only
//   select_i [1:0]    filter mode for the next frame
//   in_valid_i        SPI side presents an input pixel
//   in_ready_o        controller accepts input pixels (RUN only)
//   px_ready_sobel_i  pipeline produced an output pixel
//   abort_i           (SOBEL_FRAME_ABORT_EN only) abandon the current frame
//   start_o           one-cycle start pulse to the pipeline
//   select_o [1:0]    frame-stable select to the pipeline
//   out_valid_o       registered copy of counted px_ready_sobel_i
//   busy_o            high outside IDLE
//   frame_done_o      one-cycle end-of-frame pulse
//   error_o           sticky frame error (over-count, timeout, abort)
//   in_count_o        input pixels accepted this frame
//   out_count_o       output pixels counted this frame
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for frame_start_i, counters/error hold last frame
// ARM   | single cycle, start_o high
// RUN   | accepting input pixels until N accepted
// DRAIN | inputs closed, waiting for remaining outputs under watchdog
// DONE  | single cycle, frame_done_o high
// -----------------------------------------------------------------------------
module sobel_frame_ctrl #(
   parameter int IMG_WIDTH      = 24,
   parameter int IMG_HEIGHT     = 24,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = $clog2(IMG_WIDTH*IMG_HEIGHT+1)
) (
   input  logic             clk_i,
   input  logic             nreset_i,
   input  logic             frame_start_i,
   input  logic [1:0]       select_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             px_ready_sobel_i,
`ifdef SOBEL_FRAME_ABORT_EN
   input  logic             abort_i,
`endif
   output logic             start_o,
   output logic [1:0]       select_o,
   output logic             out_valid_o,
   output logic             busy_o,
   output logic             frame_done_o,
   output logic             error_o,
   output logic [CNT_W-1:0] in_count_o,
   output logic [CNT_W-1:0] out_count_o
);

   localparam int N_PIX = IMG_WIDTH * IMG_HEIGHT;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] N_C      = CNT_W'(N_PIX);
   localparam logic [CNT_W-1:0] N_M1_C   = CNT_W'(N_PIX - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       select_q, select_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             err_q, err_d;
   logic [WD_W-1:0]  wd_q, wd_d;

   logic abort_req;
   logic frame_active;
   logic in_accept;

`ifdef SOBEL_FRAME_ABORT_EN
   assign abort_req = abort_i;
`else
   assign abort_req = 1'b0;
`endif

   // Output pixels are counted from ARM through DRAIN so that a pipeline
   // with very short latency is not missed right after the start pulse.
   assign frame_active = (state_q == ST_ARM) || (state_q == ST_RUN) ||
                         (state_q == ST_DRAIN);
   assign in_accept    = in_valid_i && (state_q == ST_RUN);

   always_comb begin
      state_d     = state_q;
      select_d    = select_q;
      in_cnt_d    = in_cnt_q;
      out_cnt_d   = out_cnt_q;
      out_valid_d = 1'b0;
      err_d       = err_q;
      wd_d        = wd_q;

      // Outputs beyond N are reported as an error rather than counted.
      if (frame_active && px_ready_sobel_i) begin
         if (out_cnt_q != N_C) begin
            out_cnt_d   = out_cnt_q + CNT_W'(1);
            out_valid_d = 1'b1;
         end else begin
            err_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_start_i) begin
               select_d  = select_i;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               wd_d      = '0;
               err_d     = 1'b0;
               state_d   = ST_ARM;
            end
         end
         ST_ARM: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (in_accept) begin
               in_cnt_d = in_cnt_q + CNT_W'(1);
               // Leave RUN on the accept that completes the frame so that
               // in_ready_o drops before an (N+1)th pixel can be taken.
               if (in_cnt_q == N_M1_C) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (px_ready_sobel_i) begin
               wd_d = '0;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
            if (out_cnt_q == N_C) begin
               state_d = ST_DONE;
            end else if (!px_ready_sobel_i && (wd_q == WD_LAST)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (abort_req && frame_active) begin
         err_d   = 1'b1;
         state_d = ST_DONE;
      end
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q     <= ST_IDLE;
         select_q    <= 2'b00;
         in_cnt_q    <= '0;
         out_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         select_q    <= select_d;
         in_cnt_q    <= in_cnt_d;
         out_cnt_q   <= out_cnt_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
         wd_q        <= wd_d;
      end
   end

   assign start_o      = (state_q == ST_ARM);
   assign in_ready_o   = (state_q == ST_RUN);
   assign busy_o       = (state_q != ST_IDLE);
   assign frame_done_o = (state_q == ST_DONE);
   assign select_o     = select_q;
   assign out_valid_o  = out_valid_q;
   assign error_o      = err_q;
   assign in_count_o   = in_cnt_q;
   assign out_count_o  = out_cnt_q;

endmodule
